// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared proc2mem/mem2proc bus types and widths for the memory responder.
package mem_bus_pkg;
    localparam int TAG_W  = 4;
    localparam int WORD_W = 64;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_t;
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              is_load;
        logic [WORD_W-1:0] data;
        logic [CNT_W-1:0]  count;
    } resp_entry_t;
endpackage

// File: rtl/mem_resp_queue.sv
// mem_resp_queue: circular FIFO of in-flight transactions, each counting down to completion.
// Ports: clock/reset (sync, active-high); push + entry_in insert at the tail; head_ready flags a head
// whose countdown reached 0; pop removes the head; entry_out is the head; full/count give occupancy.
module mem_resp_queue
    import mem_bus_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  resp_entry_t            entry_in,
    output logic                   head_ready,
    input  logic                   pop,
    output resp_entry_t            entry_out,
    output logic                   full,
    output logic [$clog2(QDEPTH):0] count
);
    localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH) + 1;
    resp_entry_t       entries_q [QDEPTH];
    logic [QDEPTH-1:0] vld_q;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     occ_q, occ_d;
    always_comb begin
        rd_d       = pop ? (rd_q == PW'(QDEPTH-1) ? '0 : rd_q + PW'(1)) : rd_q;
        wr_d       = push ? (wr_q == PW'(QDEPTH-1) ? '0 : wr_q + PW'(1)) : wr_q;
        occ_d      = occ_q + CW'(push) - CW'(pop);
        full       = occ_q == CW'(QDEPTH);
        count      = occ_q;
        entry_out  = entries_q[rd_q];
        head_ready = vld_q[rd_q] && entries_q[rd_q].count == '0;
    end
    // The tail slot is never live when push is allowed, so a push overrides that slot's countdown.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                if (vld_q[i] && entries_q[i].count != '0)
                    entries_q[i].count <= entries_q[i].count - CNT_W'(1);
            if (pop)
                vld_q[rd_q] <= 1'b0;
            if (push) begin
                entries_q[wr_q] <= entry_in;
                vld_q[wr_q]     <= 1'b1;
            end
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory model answering proc2mem commands with tagged completions.
// Ports: clock/reset (sync, active-high); proc2mem_command/address/data from the requester;
// mem2proc_response is the combinational accept tag (0 = refused); mem2proc_tag/data are the
// registered completion pulse LATENCY cycles after acceptance.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [WORD_W-1:0] proc2mem_address,
    input  logic [WORD_W-1:0] proc2mem_data,
    output logic [TAG_W-1:0]  mem2proc_response,
    output logic [WORD_W-1:0] mem2proc_data,
    output logic [TAG_W-1:0]  mem2proc_tag
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0]      mem_q [DEPTH];
    logic [TAG_W-1:0]       tag_ctr_q, tag_ctr_d, tag_q;
    logic [WORD_W-1:0]      data_q;
    logic [AW-1:0]          idx;
    logic                   is_load, is_store, accept, full, head_ready;
    logic [$clog2(QDEPTH):0] occ;
    resp_entry_t            entry_in, entry_out;
    logic                   unused_bits;
    assign unused_bits = ^{proc2mem_address[WORD_W-1:AW], occ, entry_out.count};
    // Loads snapshot the array now; the entry's countdown starts at LATENCY-2 so the pop edge
    // plus the output register land the completion exactly LATENCY cycles after acceptance.
    always_comb begin
        idx               = proc2mem_address[AW-1:0];
        is_load           = proc2mem_command == BUS_LOAD;
        is_store          = proc2mem_command == BUS_STORE;
        accept            = (is_load || is_store) && !reset && !full;
        tag_ctr_d         = accept ? (tag_ctr_q == 4'd15 ? 4'd1 : tag_ctr_q + 4'd1) : tag_ctr_q;
        mem2proc_response = accept ? tag_ctr_q : '0;
        entry_in          = '{tag: tag_ctr_q, is_load: is_load,
                              data: is_load ? mem_q[idx] : '0, count: CNT_W'(LATENCY-2)};
        mem2proc_tag      = tag_q;
        mem2proc_data     = data_q;
    end
    mem_resp_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (accept),
        .entry_in   (entry_in),
        .head_ready (head_ready),
        .pop        (head_ready),
        .entry_out  (entry_out),
        .full       (full),
        .count      (occ)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_ctr_q <= 4'd1;
            tag_q     <= '0;
            data_q    <= '0;
        end else begin
            tag_ctr_q <= tag_ctr_d;
            tag_q     <= head_ready ? entry_out.tag : '0;
            data_q    <= head_ready && entry_out.is_load ? entry_out.data : '0;
        end
    end
    // The backing array is deliberately outside reset so its contents survive it.
    always_ff @(posedge clock)
        if (accept && is_store)
            mem_q[idx] <= proc2mem_data;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 6;
    localparam int QD    = 4;
    localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = 2'd0;
    logic [63:0] addr  = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  resp, otag;
    logic [63:0] odata;
    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [63:0] data;
    } exp_t;
    exp_t        sb [$];
    logic [63:0] mdl [int];
    logic [3:0]  tag_m = 4'd1;
    int          cyc = 0, checks = 0, errors = 0;
    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_address  (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp),
        .mem2proc_data     (odata),
        .mem2proc_tag      (otag)
    );
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask
    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d, output logic acc);
        exp_t e;
        int   idx;
        @(negedge clock);
        cmd = c; addr = a; wdata = d;
        #1;
        idx = int'(a % DEPTH);
        acc = !reset && (c == 2'd1 || c == 2'd2) && sb.size() < QD;
        chk("response", 64'(resp), acc ? 64'(tag_m) : 64'd0);
        if (acc) begin
            e.due  = cyc + LAT;
            e.tag  = tag_m;
            e.data = (c == 2'd1) ? mdl[idx] : 64'd0;
            if (c == 2'd2) mdl[idx] = d;
            sb.push_back(e);
            tag_m = (tag_m == 4'd15) ? 4'd1 : tag_m + 4'd1;
        end
        if (reset) begin
            sb.delete();
            tag_m = 4'd1;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("done_tag", 64'(otag), 64'(e.tag));
            chk("done_data", odata, e.data);
        end else begin
            chk("idle_tag", 64'(otag), 64'd0);
            chk("idle_data", odata, 64'd0);
        end
    endtask
    task automatic idle(input int n);
        logic acc;
        repeat (n) step(2'd0, 64'd0, 64'd0, acc);
    endtask
    initial begin
        logic acc;
        int   n, k;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(5);
        step(2'd3, 64'h10, D1, acc);
        step(2'd2, 64'h10, D0, acc);
        step(2'd1, 64'h10, 64'd0, acc);
        idle(LAT + 1);
        step(2'd2, 64'h1_0000_0020, D1, acc);
        step(2'd1, 64'h20, 64'd0, acc);
        idle(LAT + 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        repeat (7) step(2'd1, 64'h10, 64'd0, acc);
        idle(LAT + 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        n = 0;
        k = 0;
        while (n < 20 && k < 400) begin
            step(2'd2, 64'h100 + 64'(k), {32'hA5A5_0000, 32'(k)}, acc);
            if (acc) n++;
            k++;
        end
        chk("stores_accepted", 64'(n), 64'd20);
        idle(LAT + 1);
        step(2'd1, 64'h105, 64'd0, acc);
        idle(LAT + 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        step(2'd1, 64'h10, 64'd0, acc);
        step(2'd1, 64'h20, 64'd0, acc);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(LAT + 2);
        step(2'd1, 64'h10, 64'd0, acc);
        idle(LAT + 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
